// File: rtl/esc_pkg.sv
// Shared defaults and pulse-width arithmetic for the multi-channel ESC pulse generator.
package esc_pkg;

  localparam int unsigned ESC_MIN_PULSE      = 32'd6250;
  localparam int unsigned ESC_SCALE          = 32'd3;
  localparam int unsigned ESC_PERIOD         = 32'd20000;
  localparam int unsigned ESC_TIMEOUT_FRAMES = 32'd50;

  function automatic logic [31:0] esc_pulse_width(
    input logic [31:0] speed,
    input int unsigned min_pulse = ESC_MIN_PULSE,
    input int unsigned scale     = ESC_SCALE
  );
    return min_pulse + scale * speed;
  endfunction

endpackage

// File: rtl/esc_pwm_chan.sv
// One ESC channel: shadow setpoint, commit-time width latch and frame comparator.
module esc_pwm_chan
  import esc_pkg::*;
#(
  parameter int unsigned SPEED_W   = 32'd11,
  parameter int unsigned MIN_PULSE = ESC_MIN_PULSE,
  parameter int unsigned SCALE     = ESC_SCALE,
  parameter int unsigned CNT_W     = 32'd15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [SPEED_W-1:0] speed,
  input  logic               commit,
  input  logic               force_min,
  input  logic               armed_nxt,
  input  logic [CNT_W-1:0]   next_fcnt,
  output logic               pwm
);

  logic [SPEED_W-1:0] shadow_r;
  logic [SPEED_W-1:0] sel_s;
  logic [CNT_W-1:0]   width_r;
  logic [CNT_W-1:0]   width_nxt_s;
  logic               pwm_r;

  // Select the committed setpoint (write bypass, failsafe zero) and the width for the coming cycle.
  always_comb begin
    sel_s       = shadow_r;
    width_nxt_s = width_r;
    if (force_min) begin
      sel_s = {SPEED_W{1'b0}};
    end else if (wr_en) begin
      sel_s = speed;
    end else begin
      sel_s = shadow_r;
    end
    if (commit) begin
      width_nxt_s = CNT_W'(esc_pulse_width(32'(sel_s), MIN_PULSE, SCALE));
    end else begin
      width_nxt_s = width_r;
    end
  end

  // Shadow capture, width latch and registered pulse output (next_fcnt is the count after this edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= {SPEED_W{1'b0}};
      width_r  <= {CNT_W{1'b0}};
      pwm_r    <= 1'b0;
    end else begin
      if (wr_en) begin
        shadow_r <= speed;
      end else begin
        shadow_r <= shadow_r;
      end
      width_r <= width_nxt_s;
      pwm_r   <= armed_nxt && (next_fcnt < width_nxt_s);
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/esc_pwm_multi.sv
// Frame-synchronous multi-channel ESC pulse generator with arm gate and command-loss watchdog.
module esc_pwm_multi
  import esc_pkg::*;
#(
  parameter int unsigned NUM_CH         = 32'd4,
  parameter int unsigned SPEED_W        = 32'd11,
  parameter int unsigned MIN_PULSE      = ESC_MIN_PULSE,
  parameter int unsigned SCALE          = ESC_SCALE,
  parameter int unsigned PERIOD         = ESC_PERIOD,
  parameter int unsigned TIMEOUT_FRAMES = ESC_TIMEOUT_FRAMES,
  localparam int unsigned CH_W          = (NUM_CH > 32'd1) ? $clog2(NUM_CH) : 32'd1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt,
  input  logic [CH_W-1:0]    ch_sel,
  input  logic [SPEED_W-1:0] speed,
  input  logic               armed,
  output logic [NUM_CH-1:0]  pwm,
  output logic               frame_start,
  output logic               timeout
);

  localparam int unsigned CNT_W = $clog2(PERIOD);
  localparam int unsigned WD_W  = $clog2(TIMEOUT_FRAMES + 32'd1);

  if (MIN_PULSE + SCALE * ((32'd1 << SPEED_W) - 32'd1) >= PERIOD) begin : g_bad_timing
    $error("esc_pwm_multi: longest pulse does not fit inside PERIOD");
  end

  logic [CNT_W-1:0]  fcnt_r;
  logic [CNT_W-1:0]  next_fcnt_s;
  logic              commit_s;
  logic              valid_wr_s;
  logic [NUM_CH-1:0] wr_en_s;
  logic              fed_r;
  logic              fed_any_s;
  logic [WD_W-1:0]   wdog_r;
  logic [WD_W-1:0]   wdog_inc_s;
  logic              timeout_r;
  logic              timeout_nxt_s;
  logic              armed_q_r;
  logic              armed_nxt_s;
  logic              frame_start_r;
  logic [NUM_CH-1:0] pwm_s;

  // Frame position, write decode and the values that take effect at the frame boundary.
  always_comb begin
    commit_s = (fcnt_r == CNT_W'(PERIOD - 32'd1));
    if (commit_s) begin
      next_fcnt_s = {CNT_W{1'b0}};
    end else begin
      next_fcnt_s = fcnt_r + CNT_W'(1);
    end
    valid_wr_s = wrt && (32'(ch_sel) < NUM_CH);
    for (int i = 0; i < NUM_CH; i++) begin
      wr_en_s[i] = valid_wr_s && (32'(ch_sel) == 32'(i));
    end
    fed_any_s = fed_r || valid_wr_s;
    if (wdog_r == WD_W'(TIMEOUT_FRAMES)) begin
      wdog_inc_s = wdog_r;
    end else begin
      wdog_inc_s = wdog_r + WD_W'(1);
    end
    // A write landing on the commit cycle still counts for the frame that is ending.
    if (commit_s) begin
      timeout_nxt_s = !fed_any_s && (wdog_inc_s == WD_W'(TIMEOUT_FRAMES));
      armed_nxt_s   = armed;
    end else begin
      timeout_nxt_s = timeout_r;
      armed_nxt_s   = armed_q_r;
    end
  end

  // Frame counter, frame marker, arm latch and watchdog state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_r        <= {CNT_W{1'b0}};
      frame_start_r <= 1'b0;
      armed_q_r     <= 1'b0;
      timeout_r     <= 1'b0;
      fed_r         <= 1'b0;
      wdog_r        <= {WD_W{1'b0}};
    end else begin
      fcnt_r        <= next_fcnt_s;
      frame_start_r <= commit_s;
      armed_q_r     <= armed_nxt_s;
      timeout_r     <= timeout_nxt_s;
      if (commit_s) begin
        fed_r  <= 1'b0;
        wdog_r <= fed_any_s ? {WD_W{1'b0}} : wdog_inc_s;
      end else if (valid_wr_s) begin
        fed_r  <= 1'b1;
        wdog_r <= {WD_W{1'b0}};
      end else begin
        fed_r  <= fed_r;
        wdog_r <= wdog_r;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    esc_pwm_chan #(
      .SPEED_W  (SPEED_W),
      .MIN_PULSE(MIN_PULSE),
      .SCALE    (SCALE),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en_s[i]),
      .speed    (speed),
      .commit   (commit_s),
      .force_min(timeout_nxt_s),
      .armed_nxt(armed_nxt_s),
      .next_fcnt(next_fcnt_s),
      .pwm      (pwm_s[i])
    );
  end

  assign pwm         = pwm_s;
  assign frame_start = frame_start_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_esc_pwm_multi.sv
// Directed and randomised checks of esc_pwm_multi against a frame-level behavioural model.
module tb_esc_pwm_multi;

  localparam int NCH  = 5;
  localparam int SW   = 6;
  localparam int MINP = 40;
  localparam int SC   = 3;
  localparam int P    = 300;
  localparam int TO   = 6;
  localparam int CHW  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wrt = 1'b0;
  logic           armed = 1'b0;
  logic [CHW-1:0] ch_sel = '0;
  logic [SW-1:0]  speed = '0;
  logic [NCH-1:0] pwm;
  logic           frame_start;
  logic           timeout;

  always #5 clk = ~clk;

  esc_pwm_multi #(
    .NUM_CH(NCH), .SPEED_W(SW), .MIN_PULSE(MINP), .SCALE(SC),
    .PERIOD(P), .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wrt(wrt), .ch_sel(ch_sel), .speed(speed),
    .armed(armed), .pwm(pwm), .frame_start(frame_start), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  // Model: t = clock edges since reset release; frame f covers t in [f*P, f*P+P-1].
  int             t;
  int             m_shadow[NCH];
  int             m_width[NCH];
  bit             m_armed, m_fed, m_to, m_fs;
  int             m_idle;
  logic [NCH-1:0] m_pwm;
  int             hi_cnt[64][NCH];

  function automatic void model_reset();
    t = 0; m_armed = 0; m_fed = 0; m_to = 0; m_fs = 0; m_idle = 0; m_pwm = '0;
    for (int i = 0; i < NCH; i++) begin
      m_shadow[i] = 0;
      m_width[i]  = 0;
    end
    for (int f = 0; f < 64; f++)
      for (int i = 0; i < NCH; i++) hi_cnt[f][i] = 0;
  endfunction

  function automatic void model_edge(bit w, int ch, int sp);
    bit valid  = w && (ch < NCH);
    bit commit = ((t % P) == P - 1);
    if (valid) m_shadow[ch] = sp;
    if (commit) begin
      if (m_fed || valid) m_idle = 0;
      else m_idle++;
      m_to = (m_idle >= TO);
      for (int i = 0; i < NCH; i++) m_width[i] = m_to ? MINP : MINP + SC * m_shadow[i];
      m_armed = armed;
      m_fed   = 0;
    end else if (valid) begin
      m_fed = 1;
    end
    m_fs = commit;
    t++;
    for (int i = 0; i < NCH; i++) m_pwm[i] = m_armed && ((t % P) < m_width[i]);
  endfunction

  task automatic tick(input bit w, input int ch, input int sp);
    wrt = w; ch_sel = CHW'(ch); speed = SW'(sp);
    @(posedge clk);
    model_edge(w, ch, sp);
    #1;
    if (t / P < 64)
      for (int i = 0; i < NCH; i++) hi_cnt[t / P][i] += int'(pwm[i]);
    wrt = 1'b0;
  endtask

  task automatic test_reset();
    int first_fs;
    rst_n = 1'b0; armed = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({timeout, frame_start, pwm} !== '0) begin
      errors++; $display("FAIL reset_hold got %b required 0", {timeout, frame_start, pwm});
    end
    @(negedge clk); rst_n = 1'b1; model_reset();
    first_fs = -1;
    while (t < P) begin
      tick(0, 0, 0);
      if (frame_start === 1'b1 && first_fs < 0) first_fs = t;
      checks++;
      if ({timeout, frame_start, pwm} !== {m_to, m_fs, m_pwm}) begin
        errors++; $display("FAIL reset_frame t=%0d got %b required %b", t, {timeout, frame_start, pwm}, {m_to, m_fs, m_pwm});
      end
    end
    checks++;
    if (first_fs !== P) begin
      errors++; $display("FAIL first_frame_start got %0d required %0d", first_fs, P);
    end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (hi_cnt[0][i] !== 0) begin
        errors++; $display("FAIL first_frame_low ch%0d got %0d required 0", i, hi_cnt[0][i]);
      end
    end
  endtask

  task automatic test_idle();
    while (t < 3 * P) begin
      tick(0, 0, 0);
      checks++;
      if ({timeout, frame_start, pwm} !== {m_to, m_fs, m_pwm}) begin
        errors++; $display("FAIL idle t=%0d got %b required %b", t, {timeout, frame_start, pwm}, {m_to, m_fs, m_pwm});
      end
    end
    for (int f = 1; f <= 2; f++)
      for (int i = 0; i < NCH; i++) begin
        checks++;
        if (hi_cnt[f][i] !== MINP) begin
          errors++; $display("FAIL idle_width f%0d ch%0d got %0d required %0d", f, i, hi_cnt[f][i], MINP);
        end
      end
  endtask

  task automatic test_write_mid();
    while (t < 5 * P) begin
      tick(t == 3 * P + 150, 2, 63);
      checks++;
      if ({timeout, frame_start, pwm} !== {m_to, m_fs, m_pwm}) begin
        errors++; $display("FAIL write_mid t=%0d got %b required %b", t, {timeout, frame_start, pwm}, {m_to, m_fs, m_pwm});
      end
    end
    checks++;
    if (hi_cnt[3][2] !== MINP) begin
      errors++; $display("FAIL write_mid_same_frame got %0d required %0d", hi_cnt[3][2], MINP);
    end
    checks++;
    if (hi_cnt[4][2] !== MINP + SC * 63) begin
      errors++; $display("FAIL write_mid_max got %0d required %0d", hi_cnt[4][2], MINP + SC * 63);
    end
    checks++;
    if (hi_cnt[4][0] !== MINP) begin
      errors++; $display("FAIL write_mid_other got %0d required %0d", hi_cnt[4][0], MINP);
    end
  endtask

  task automatic test_commit_bypass();
    while (t < 8 * P) begin
      tick((t == 6 * P - 1) || (t == 6 * P), 1, (t == 6 * P - 1) ? 10 : 20);
      checks++;
      if ({timeout, frame_start, pwm} !== {m_to, m_fs, m_pwm}) begin
        errors++; $display("FAIL bypass t=%0d got %b required %b", t, {timeout, frame_start, pwm}, {m_to, m_fs, m_pwm});
      end
    end
    checks++;
    if (hi_cnt[6][1] !== MINP + SC * 10) begin
      errors++; $display("FAIL bypass_commit_write got %0d required %0d", hi_cnt[6][1], MINP + SC * 10);
    end
    checks++;
    if (hi_cnt[7][1] !== MINP + SC * 20) begin
      errors++; $display("FAIL bypass_next_write got %0d required %0d", hi_cnt[7][1], MINP + SC * 20);
    end
  endtask

  task automatic test_armed_drop();
    while (t < 11 * P) begin
      if (t == 8 * P + 30) armed = 1'b0;
      if (t == 9 * P + 150) armed = 1'b1;
      tick(t == 8 * P + 100, 4, 5);
      checks++;
      if ({timeout, frame_start, pwm} !== {m_to, m_fs, m_pwm}) begin
        errors++; $display("FAIL armed t=%0d got %b required %b", t, {timeout, frame_start, pwm}, {m_to, m_fs, m_pwm});
      end
    end
    checks++;
    if (hi_cnt[8][2] !== MINP + SC * 63) begin
      errors++; $display("FAIL armed_pulse_completes got %0d required %0d", hi_cnt[8][2], MINP + SC * 63);
    end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (hi_cnt[9][i] !== 0) begin
        errors++; $display("FAIL disarmed_frame ch%0d got %0d required 0", i, hi_cnt[9][i]);
      end
    end
    checks++;
    if (hi_cnt[10][4] !== MINP + SC * 5) begin
      errors++; $display("FAIL rearm got %0d required %0d", hi_cnt[10][4], MINP + SC * 5);
    end
  endtask

  task automatic test_timeout();
    bit w;
    int ch, sp;
    while (t < 21 * P) begin
      w = 0; ch = 0; sp = 0;
      if (t == 11 * P + 50) begin w = 1; ch = 0; sp = 20; end
      if (t == 18 * P + 100) begin w = 1; ch = 5; sp = 63; end
      if (t == 19 * P + 100) begin w = 1; ch = 3; sp = 0; end
      tick(w, ch, sp);
      checks++;
      if ({timeout, frame_start, pwm} !== {m_to, m_fs, m_pwm}) begin
        errors++; $display("FAIL timeout_cycle t=%0d got %b required %b", t, {timeout, frame_start, pwm}, {m_to, m_fs, m_pwm});
      end
      if (t == 18 * P - 1 || t == 18 * P || t == 20 * P - 1 || t == 20 * P) begin
        checks++;
        if (timeout !== ((t >= 18 * P && t < 20 * P) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL timeout_edge t=%0d got %b", t, timeout);
        end
      end
    end
    checks++;
    if (hi_cnt[17][0] !== MINP + SC * 20) begin
      errors++; $display("FAIL pre_timeout_width got %0d required %0d", hi_cnt[17][0], MINP + SC * 20);
    end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (hi_cnt[19][i] !== MINP) begin
        errors++; $display("FAIL failsafe_width ch%0d got %0d required %0d", i, hi_cnt[19][i], MINP);
      end
    end
    checks++;
    if (hi_cnt[20][0] !== MINP + SC * 20) begin
      errors++; $display("FAIL recovered_ch0 got %0d required %0d", hi_cnt[20][0], MINP + SC * 20);
    end
    checks++;
    if (hi_cnt[20][4] !== MINP + SC * 5) begin
      errors++; $display("FAIL recovered_ch4 got %0d required %0d", hi_cnt[20][4], MINP + SC * 5);
    end
  endtask

  task automatic test_reset_mid();
    while (t < 21 * P + 130) begin
      tick(0, 0, 0);
      checks++;
      if ({timeout, frame_start, pwm} !== {m_to, m_fs, m_pwm}) begin
        errors++; $display("FAIL pre_reset t=%0d got %b required %b", t, {timeout, frame_start, pwm}, {m_to, m_fs, m_pwm});
      end
    end
    checks++;
    if (pwm[2] !== 1'b1) begin
      errors++; $display("FAIL pre_reset_high got %b required 1", pwm[2]);
    end
    #2; rst_n = 1'b0; #1;
    checks++;
    if ({timeout, frame_start, pwm} !== '0) begin
      errors++; $display("FAIL async_reset got %b required 0", {timeout, frame_start, pwm});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; model_reset();
    while (t < P) begin
      tick(0, 0, 0);
      checks++;
      if ({timeout, frame_start, pwm} !== {m_to, m_fs, m_pwm}) begin
        errors++; $display("FAIL post_reset t=%0d got %b required %b", t, {timeout, frame_start, pwm}, {m_to, m_fs, m_pwm});
      end
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++; $display("FAIL post_reset_frame_start got %b required 1", frame_start);
    end
  endtask

  task automatic test_random();
    bit w;
    while (t < 21 * P) begin
      w = (t >= 9 * P) && ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 399) == 0) armed = ~armed;
      tick(w, int'($urandom_range(0, 7)), int'($urandom_range(0, 63)));
      checks++;
      if ({timeout, frame_start, pwm} !== {m_to, m_fs, m_pwm}) begin
        errors++; $display("FAIL random t=%0d got %b required %b", t, {timeout, frame_start, pwm}, {m_to, m_fs, m_pwm});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit expired at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_write_mid();
    test_commit_bypass();
    test_armed_drop();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
